keyboard_cursor_ctrl: RTL and testbench

Converts the 8-bit USB HID keycode that the SoC's keycode PIO exports into board-cursor motion and a two-click move request for the chess game. It sits directly downstream of the SoC keycode output in the top level. It drives the board cursor and selection overlay, and hands completed moves (source/destination square) to the game-logic block over a valid/ready handshake.

---
 rtl/chess_pkg.sv | 41 ++++
 rtl/keyboard_cursor_ctrl_key_repeat.sv | 60 ++++++
 rtl/keyboard_cursor_ctrl.sv | 131 +++++++++++++
 tb/tb_keyboard_cursor_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/chess_pkg.sv
// Shared types and keycode constants for the keyboard-driven chess cursor.
// Keycodes are USB HID usage IDs as exported by the SoC keycode PIO.
package chess_pkg;

    localparam logic [7:0] KC_RIGHT = 8'h4F;
    localparam logic [7:0] KC_D     = 8'h07;
    localparam logic [7:0] KC_LEFT  = 8'h50;
    localparam logic [7:0] KC_A     = 8'h04;
    localparam logic [7:0] KC_UP    = 8'h52;
    localparam logic [7:0] KC_W     = 8'h1A;
    localparam logic [7:0] KC_DOWN  = 8'h51;
    localparam logic [7:0] KC_S     = 8'h16;
    localparam logic [7:0] KC_ENTER = 8'h28;
    localparam logic [7:0] KC_SPACE = 8'h2C;
    localparam logic [7:0] KC_ESC   = 8'h29;

    typedef logic [5:0] sq_t;  // {y[2:0], x[2:0]}

    typedef enum logic [1:0] {IDLE, SRC_HELD, MOVE_PEND} sel_state_t;

    typedef enum logic [2:0] {
        KEY_NONE, KEY_RIGHT, KEY_LEFT, KEY_UP, KEY_DOWN, KEY_SELECT, KEY_CANCEL
    } key_class_t;

    function automatic key_class_t decode_key(input logic [7:0] kc);
        case (kc)
            KC_RIGHT, KC_D:     return KEY_RIGHT;
            KC_LEFT,  KC_A:     return KEY_LEFT;
            KC_UP,    KC_W:     return KEY_UP;
            KC_DOWN,  KC_S:     return KEY_DOWN;
            KC_ENTER, KC_SPACE: return KEY_SELECT;
            KC_ESC:             return KEY_CANCEL;
            default:            return KEY_NONE;
        endcase
    endfunction

    function automatic logic is_arrow(input key_class_t k);
        return (k == KEY_RIGHT) || (k == KEY_LEFT) || (k == KEY_UP) || (k == KEY_DOWN);
    endfunction

endpackage

// File: rtl/keyboard_cursor_ctrl_key_repeat.sv
// Press-edge detection on the raw keycode plus typematic auto-repeat for
// direction keys; emits a one-cycle step pulse and the decoded key class.
module key_repeat
    import chess_pkg::*;
#(
    parameter int REPEAT_DELAY  = 25_000_000,
    parameter int REPEAT_PERIOD = 5_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] keycode,
    output logic       step,
    output key_class_t key_class
);

    localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] DELAY_LD  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LD = CNT_W'(REPEAT_PERIOD - 1);

    logic [7:0]       kc_prev;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             press;
    logic             held;

    assign key_class = decode_key(keycode);
    assign press     = (keycode != kc_prev) && (keycode != 8'h00);
    assign held      = (keycode == kc_prev) && (keycode != 8'h00) && is_arrow(key_class);

    always_comb begin
        cnt_d = cnt_q;
        step  = 1'b0;
        if (keycode == 8'h00) begin
            cnt_d = '0;
        end else if (press) begin
            step  = 1'b1;
            cnt_d = is_arrow(key_class) ? DELAY_LD : '0;
        end else if (held) begin
            // counter hitting zero marks the repeat edge; reload for the next one
            if (cnt_q == '0) begin
                step  = 1'b1;
                cnt_d = PERIOD_LD;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kc_prev <= 8'h00;
            cnt_q   <= '0;
        end else begin
            kc_prev <= keycode;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/keyboard_cursor_ctrl.sv
// Keyboard-to-board cursor control: moves the cursor on key steps and builds
// a two-click (source, destination) move request with a valid/ready handoff.
module keyboard_cursor_ctrl
    import chess_pkg::*;
#(
    parameter bit WRAP          = 1'b1,
    parameter int INIT_X        = 4,
    parameter int INIT_Y        = 0,
    parameter int REPEAT_DELAY  = 25_000_000,
    parameter int REPEAT_PERIOD = 5_000_000
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic [7:0] keycode,
    output logic [2:0] cursor_x,
    output logic [2:0] cursor_y,
    output logic       sel_active,
    output sq_t        sel_sq,
    output logic       move_valid,
    output sq_t        move_src,
    output sq_t        move_dst,
    input  logic       move_ready
);

    sel_state_t state_q, state_d;
    logic [2:0] x_d, y_d;
    logic       sel_active_d, move_valid_d;
    sq_t        sel_sq_d, move_src_d, move_dst_d, cur_sq;
    logic       step;
    key_class_t key_class;

    key_repeat #(
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_key_repeat (
        .clk      (Clk),
        .rst_n    (Reset_n),
        .keycode  (keycode),
        .step     (step),
        .key_class(key_class)
    );

    function automatic logic [2:0] move_coord(input logic [2:0] c, input logic inc);
        if (WRAP)
            return inc ? c + 3'd1 : c - 3'd1;
        if (inc)
            return (c == 3'd7) ? c : c + 3'd1;
        return (c == 3'd0) ? c : c - 3'd1;
    endfunction

    assign cur_sq = {cursor_y, cursor_x};

    always_comb begin
        state_d      = state_q;
        x_d          = cursor_x;
        y_d          = cursor_y;
        sel_active_d = sel_active;
        sel_sq_d     = sel_sq;
        move_valid_d = move_valid;
        move_src_d   = move_src;
        move_dst_d   = move_dst;

        if (step) begin
            case (key_class)
                KEY_RIGHT: x_d = move_coord(cursor_x, 1'b1);
                KEY_LEFT:  x_d = move_coord(cursor_x, 1'b0);
                KEY_UP:    y_d = move_coord(cursor_y, 1'b1);
                KEY_DOWN:  y_d = move_coord(cursor_y, 1'b0);
                default:   ;
            endcase
        end

        case (state_q)
            IDLE: begin
                if (step && key_class == KEY_SELECT) begin
                    state_d      = SRC_HELD;
                    sel_sq_d     = cur_sq;
                    sel_active_d = 1'b1;
                end
            end
            SRC_HELD: begin
                if (step && key_class == KEY_CANCEL) begin
                    state_d      = IDLE;
                    sel_active_d = 1'b0;
                end else if (step && key_class == KEY_SELECT) begin
                    if (cur_sq == sel_sq) begin
                        state_d      = IDLE;
                        sel_active_d = 1'b0;
                    end else begin
                        state_d      = MOVE_PEND;
                        move_src_d   = sel_sq;
                        move_dst_d   = cur_sq;
                        move_valid_d = 1'b1;
                    end
                end
            end
            MOVE_PEND: begin
                // move_valid is always high here, so ready alone completes the handoff
                if (move_ready) begin
                    state_d      = IDLE;
                    move_valid_d = 1'b0;
                    sel_active_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= IDLE;
            cursor_x   <= 3'(INIT_X);
            cursor_y   <= 3'(INIT_Y);
            sel_active <= 1'b0;
            sel_sq     <= '0;
            move_valid <= 1'b0;
            move_src   <= '0;
            move_dst   <= '0;
        end else begin
            state_q    <= state_d;
            cursor_x   <= x_d;
            cursor_y   <= y_d;
            sel_active <= sel_active_d;
            sel_sq     <= sel_sq_d;
            move_valid <= move_valid_d;
            move_src   <= move_src_d;
            move_dst   <= move_dst_d;
        end
    end

endmodule

// File: tb/tb_keyboard_cursor_ctrl.sv
// Bench for keyboard_cursor_ctrl: a wrapping and a saturating instance share
// stimulus and are compared every cycle against an event-level reference model.
module tb_keyboard_cursor_ctrl;

    localparam int RD = 10;
    localparam int RP = 4;

    logic       Clk;
    logic       Reset_n;
    logic [7:0] kc;
    logic       rdy;
    logic [2:0] cx [2];
    logic [2:0] cy [2];
    logic       sa [2];
    logic       mv [2];
    logic [5:0] ss [2];
    logic [5:0] ms [2];
    logic [5:0] md [2];

    int vectors     = 0;
    int miscompares = 0;

    // reference model state; index 0 = wrapping, 1 = saturating
    int m_x [2], m_y [2], m_st [2], m_sa [2], m_ss [2], m_mv [2], m_src [2], m_dst [2];
    int prev_kc;
    int held;

    keyboard_cursor_ctrl #(
        .WRAP(1'b1), .INIT_X(4), .INIT_Y(0), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut_wrap (
        .Clk(Clk), .Reset_n(Reset_n), .keycode(kc),
        .cursor_x(cx[0]), .cursor_y(cy[0]), .sel_active(sa[0]), .sel_sq(ss[0]),
        .move_valid(mv[0]), .move_src(ms[0]), .move_dst(md[0]), .move_ready(rdy)
    );

    keyboard_cursor_ctrl #(
        .WRAP(1'b0), .INIT_X(4), .INIT_Y(0), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut_sat (
        .Clk(Clk), .Reset_n(Reset_n), .keycode(kc),
        .cursor_x(cx[1]), .cursor_y(cy[1]), .sel_active(sa[1]), .sel_sq(ss[1]),
        .move_valid(mv[1]), .move_src(ms[1]), .move_dst(md[1]), .move_ready(rdy)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        vectors++;
        assert (got === exp)
        else begin
            miscompares++;
            $error("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int w = 0; w < 2; w++) begin
            m_x[w] = 4; m_y[w] = 0; m_st[w] = 0; m_sa[w] = 0; m_ss[w] = 0;
            m_mv[w] = 0; m_src[w] = 0; m_dst[w] = 0;
        end
        prev_kc = 0;
        held    = -1;
    endtask

    function automatic int clamp_or_wrap(input int v, input int w);
        if (w == 0) return (v + 8) % 8;
        if (v < 0) return 0;
        if (v > 7) return 7;
        return v;
    endfunction

    // One clock edge of behaviour: steps happen at press time and at
    // RD, RD+RP, RD+2RP... cycles after the press while the key stays held.
    task automatic model_edge();
        int  dx, dy, sq, k;
        bit  press, step, arrow, sel, can;
        k  = int'(kc);
        dx = 0; dy = 0;
        case (k)
            'h4F, 'h07: dx = 1;
            'h50, 'h04: dx = -1;
            'h52, 'h1A: dy = 1;
            'h51, 'h16: dy = -1;
            default: ;
        endcase
        arrow = (dx != 0) || (dy != 0);
        press = (k != prev_kc) && (k != 0);
        step  = 0;
        if (k == 0) held = -1;
        else if (press) begin
            step = 1;
            held = arrow ? 0 : -1;
        end else if (held >= 0) begin
            held++;
            if (held >= RD && ((held - RD) % RP) == 0) step = 1;
        end
        sel = press && (k == 'h28 || k == 'h2C);
        can = press && (k == 'h29);
        for (int w = 0; w < 2; w++) begin
            sq = m_y[w] * 8 + m_x[w];
            if (step) begin
                m_x[w] = clamp_or_wrap(m_x[w] + dx, w);
                m_y[w] = clamp_or_wrap(m_y[w] + dy, w);
            end
            case (m_st[w])
                0: if (sel) begin m_st[w] = 1; m_ss[w] = sq; m_sa[w] = 1; end
                1: begin
                    if (can) begin m_st[w] = 0; m_sa[w] = 0; end
                    else if (sel) begin
                        if (sq == m_ss[w]) begin m_st[w] = 0; m_sa[w] = 0; end
                        else begin
                            m_st[w] = 2; m_mv[w] = 1; m_src[w] = m_ss[w]; m_dst[w] = sq;
                        end
                    end
                end
                default: if (rdy) begin m_st[w] = 0; m_mv[w] = 0; m_sa[w] = 0; end
            endcase
        end
        prev_kc = k;
    endtask

    task automatic check_all();
        for (int w = 0; w < 2; w++) begin
            check($sformatf("cursor_x[%0d]", w), 8'(cx[w]), 8'(m_x[w]));
            check($sformatf("cursor_y[%0d]", w), 8'(cy[w]), 8'(m_y[w]));
            check($sformatf("sel_active[%0d]", w), 8'(sa[w]), 8'(m_sa[w]));
            check($sformatf("sel_sq[%0d]", w), 8'(ss[w]), 8'(m_ss[w]));
            check($sformatf("move_valid[%0d]", w), 8'(mv[w]), 8'(m_mv[w]));
            check($sformatf("move_src[%0d]", w), 8'(ms[w]), 8'(m_src[w]));
            check($sformatf("move_dst[%0d]", w), 8'(md[w]), 8'(m_dst[w]));
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge Clk);
            if (Reset_n) model_edge();
            #1;
            check_all();
        end
    endtask

    task automatic press_key(input logic [7:0] code, input int hold);
        kc = code;
        tick(hold);
        kc = 8'h00;
        tick(1);
    endtask

    // Called one unit after an edge: reset lands mid-cycle and is checked before any edge.
    task automatic apply_reset();
        Reset_n = 1'b0;
        model_reset();
        #1;
        check_all();
        @(posedge Clk);
        #1;
        Reset_n = 1'b1;
    endtask

    initial begin
        logic [7:0] codes [14];
        codes = '{8'h4F, 8'h07, 8'h50, 8'h04, 8'h52, 8'h1A, 8'h51, 8'h16,
                  8'h28, 8'h2C, 8'h29, 8'h00, 8'h00, 8'h4F};
        kc      = 8'h00;
        rdy     = 1'b0;
        Reset_n = 1'b1;
        #1;
        Reset_n = 1'b0;
        model_reset();
        #2;
        check_all();
        check("reset_x", 8'(cx[0]), 8'd4);
        @(posedge Clk);
        #1;
        Reset_n = 1'b1;

        // held Right: press + repeats at +10,+14,+18,+22,+26
        kc = 8'h4F;
        tick(30);
        kc = 8'h00;
        tick(10);
        check("repeat_wrap_x", 8'(cx[0]), 8'd2);
        check("repeat_sat_x", 8'(cx[1]), 8'd7);

        // saturation at the left edge
        apply_reset();
        repeat (4) press_key(8'h50, 1);
        check("left_to_edge_x", 8'(cx[1]), 8'd0);
        repeat (3) press_key(8'h50, 1);
        check("sat_hold_x", 8'(cx[1]), 8'd0);
        check("wrap_past_x", 8'(cx[0]), 8'd5);

        // move handshake
        apply_reset();
        press_key(8'h52, 1);
        press_key(8'h28, 1);
        check("src_sel_sq", 8'(ss[0]), 8'h0C);
        press_key(8'h52, 1);
        press_key(8'h52, 1);
        kc = 8'h28;
        tick(1);
        check("pend_valid", 8'(mv[0]), 8'd1);
        check("pend_src", 8'(ms[0]), 8'h0C);
        check("pend_dst", 8'(md[0]), 8'h1C);
        kc = 8'h00;
        tick(5);
        check("stall_dst", 8'(md[1]), 8'h1C);
        rdy = 1'b1;
        tick(1);
        rdy = 1'b0;
        check("accept_valid", 8'(mv[0]), 8'd0);
        check("accept_sel", 8'(sa[0]), 8'd0);

        // deselect and cancel
        press_key(8'h28, 1);
        press_key(8'h28, 1);
        check("deselect_sel", 8'(sa[0]), 8'd0);
        check("deselect_valid", 8'(mv[0]), 8'd0);
        press_key(8'h28, 1);
        press_key(8'h29, 1);
        check("cancel_sel", 8'(sa[0]), 8'd0);

        // direct key change, then SELECT ignored while a move is pending
        apply_reset();
        kc = 8'h4F;
        tick(1);
        kc = 8'h52;
        tick(1);
        kc = 8'h00;
        tick(1);
        check("chg_x", 8'(cx[0]), 8'd5);
        check("chg_y", 8'(cy[0]), 8'd1);
        press_key(8'h28, 1);
        press_key(8'h4F, 1);
        press_key(8'h28, 1);
        press_key(8'h4F, 1);
        press_key(8'h28, 1);
        check("pend_ignore_dst", 8'(md[0]), 8'h0E);
        check("pend_ignore_valid", 8'(mv[0]), 8'd1);
        check("pend_move_x", 8'(cx[0]), 8'd7);
        rdy = 1'b1;
        tick(1);
        rdy = 1'b0;

        // randomized key traffic with sporadic ready and one mid-run reset
        for (int i = 0; i < 300; i++) begin
            int hold;
            if (i == 150) apply_reset();
            if ($urandom_range(0, 9) == 0) kc = 8'($urandom_range(0, 255));
            else kc = codes[$urandom_range(0, 13)];
            hold = ($urandom_range(0, 7) == 0) ? $urandom_range(10, 25) : $urandom_range(1, 6);
            repeat (hold) begin
                rdy = ($urandom_range(0, 3) == 0);
                tick(1);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
